// File: rtl/platform_nios_oci_dct_packer.sv
// Producer side of the OCI direct-compressed-trace path: packs 2-bit trace codes
// into a 30-bit buffer and seals full or flushed buffers into 36-bit trace words.
module platform_nios_oci_dct_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  code,
  input  logic        code_valid,
  input  logic        flush,
  input  logic        tw_ready,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic [35:0] tw,
  output logic        tw_valid,
  output logic        overflow
);

  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_e;

  localparam logic [3:0] FULL_COUNT = 4'd15;

  slot_state_e state_q, state_d;
  logic        flush_pending, pend_d;
  logic [29:0] buf_d, post_buf;
  logic [3:0]  cnt_d, post_cnt;
  logic [35:0] tw_d;
  logic        ovf_d;
  logic        slot_free;
  logic        seal;

  assign tw_valid  = (state_q == SLOT_FULL);
  assign slot_free = (state_q == SLOT_EMPTY) || tw_ready;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    buf_d    = dct_buffer;
    cnt_d    = dct_count;
    tw_d     = tw;
    ovf_d    = overflow;
    pend_d   = flush_pending || flush;
    seal     = 1'b0;
    post_buf = code_valid ? {dct_buffer[27:0], code} : dct_buffer;
    post_cnt = dct_count + {3'd0, code_valid};

    if (dct_count == FULL_COUNT) begin
      // Held full buffer: it seals as soon as the slot frees, and a code arriving
      // that same cycle starts the fresh buffer; otherwise the code is dropped.
      if (slot_free) begin
        seal   = 1'b1;
        tw_d   = {2'b10, dct_count, dct_buffer};
        buf_d  = code_valid ? {28'd0, code} : 30'd0;
        cnt_d  = code_valid ? 4'd1 : 4'd0;
        pend_d = 1'b0;
      end else if (code_valid) begin
        ovf_d = 1'b1;
      end
    end else begin
      buf_d = post_buf;
      cnt_d = post_cnt;
      if (post_cnt == 4'd0) begin
        pend_d = 1'b0;
      end else if (((post_cnt == FULL_COUNT) || pend_d) && slot_free) begin
        seal   = 1'b1;
        tw_d   = {2'b10, post_cnt, post_buf};
        buf_d  = 30'd0;
        cnt_d  = 4'd0;
        pend_d = 1'b0;
      end
    end

    case (state_q)
      SLOT_EMPTY: if (seal) state_d = SLOT_FULL;
      SLOT_FULL:  if (seal) state_d = SLOT_FULL;
                  else if (tw_ready) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= SLOT_EMPTY;
      dct_buffer    <= 30'd0;
      dct_count     <= 4'd0;
      tw            <= 36'd0;
      overflow      <= 1'b0;
      flush_pending <= 1'b0;
    end else begin
      state_q       <= state_d;
      dct_buffer    <= buf_d;
      dct_count     <= cnt_d;
      tw            <= tw_d;
      overflow      <= ovf_d;
      flush_pending <= pend_d;
    end
  end

endmodule

// File: tb/tb_platform_nios_oci_dct_packer.sv
// Self-checking bench for platform_nios_oci_dct_packer: table-driven fill plus
// hand-written corner sequences, with sealed words checked through a scoreboard.
module tb_platform_nios_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  code;
  logic        code_valid;
  logic        flush;
  logic        tw_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic [35:0] tw;
  logic        tw_valid;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [35:0] sb[$];

  typedef struct {
    logic       cv;
    logic [1:0] code;
    logic       fl;
    logic       rdy;
    logic [3:0] exp_count;
    logic       exp_valid;
  } vec_t;

  vec_t fill_tbl[15];

  platform_nios_oci_dct_packer dut (
    .clk        (clk),
    .reset      (reset),
    .code       (code),
    .code_valid (code_valid),
    .flush      (flush),
    .tw_ready   (tw_ready),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count),
    .tw         (tw),
    .tw_valid   (tw_valid),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Drive one cycle; any word accepted this cycle is compared against the scoreboard.
  task automatic step(input logic cv, input logic [1:0] c, input logic fl, input logic rdy);
    logic [35:0] exp_w;
    code_valid = cv;
    code       = c;
    flush      = fl;
    tw_ready   = rdy;
    @(negedge clk);
    if (tw_valid && tw_ready) begin
      if (sb.size() == 0) check("sb_unexpected_word", 64'(sb.size()), 64'd1);
      else begin
        exp_w = sb.pop_front();
        check("tw_word", 64'(tw), 64'(exp_w));
      end
    end
    @(posedge clk);
    #1;
    code_valid = 1'b0;
    flush      = 1'b0;
  endtask

  initial begin
    logic [29:0] acc;

    reset = 1'b1; code = 2'b00; code_valid = 1'b0; flush = 1'b0; tw_ready = 1'b0;

    acc = 30'd0;
    for (int i = 0; i < 15; i++) begin
      fill_tbl[i].cv        = 1'b1;
      fill_tbl[i].code      = 2'((i % 3) + 1);
      fill_tbl[i].fl        = 1'b0;
      fill_tbl[i].rdy       = 1'b1;
      fill_tbl[i].exp_count = (i == 14) ? 4'd0 : 4'(i + 1);
      fill_tbl[i].exp_valid = (i == 14);
      acc = {acc[27:0], fill_tbl[i].code};
    end

    repeat (2) @(posedge clk);
    #1;
    check("rst_buffer",   64'(dct_buffer), 64'd0);
    check("rst_count",    64'(dct_count),  64'd0);
    check("rst_tw_valid", 64'(tw_valid),   64'd0);
    check("rst_overflow", 64'(overflow),   64'd0);
    reset = 1'b0;

    // Fill: 15 cycling codes seal on the 15th edge.
    sb.push_back({2'b10, 4'hF, acc});
    for (int i = 0; i < 15; i++) begin
      step(fill_tbl[i].cv, fill_tbl[i].code, fill_tbl[i].fl, fill_tbl[i].rdy);
      check("fill_count", 64'(dct_count), 64'(fill_tbl[i].exp_count));
      check("fill_valid", 64'(tw_valid),  64'(fill_tbl[i].exp_valid));
    end
    check("fill_tw_now", 64'(tw), 64'({2'b10, 4'hF, acc}));
    step(1'b0, 2'b00, 1'b0, 1'b1);
    check("fill_drained", 64'(tw_valid), 64'd0);

    // Partial flush of 3 codes.
    step(1'b1, 2'b11, 1'b0, 1'b1);
    step(1'b1, 2'b10, 1'b0, 1'b1);
    step(1'b1, 2'b01, 1'b0, 1'b1);
    check("pf_buffer", 64'(dct_buffer), 64'h39);
    check("pf_count",  64'(dct_count),  64'd3);
    sb.push_back({2'b10, 4'h3, 24'h0, 6'b111001});
    step(1'b0, 2'b00, 1'b1, 1'b1);
    check("pf_valid", 64'(tw_valid),  64'd1);
    check("pf_count0", 64'(dct_count), 64'd0);
    step(1'b0, 2'b00, 1'b0, 1'b1);
    check("pf_drained", 64'(tw_valid), 64'd0);

    // Flush with a code in the same cycle at count 4.
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 1'b0, 1'b1);
    sb.push_back({2'b10, 4'h5, 20'h0, 10'h06E});
    step(1'b1, 2'b10, 1'b1, 1'b1);
    check("fc_valid", 64'(tw_valid),  64'd1);
    check("fc_count", 64'(dct_count), 64'd0);
    step(1'b0, 2'b00, 1'b0, 1'b1);

    // Backpressure: sealed word, held full buffer, then a dropped code.
    for (int i = 0; i < 15; i++) step(1'b1, 2'b11, 1'b0, 1'b0);
    sb.push_back({2'b10, 4'hF, 30'h3FFF_FFFF});
    for (int i = 0; i < 15; i++) step(1'b1, 2'b01, 1'b0, 1'b0);
    check("bp_count15", 64'(dct_count),  64'd15);
    check("bp_buffer",  64'(dct_buffer), 64'h1555_5555);
    check("bp_tw_hold", 64'(tw),         64'({2'b10, 4'hF, 30'h3FFF_FFFF}));
    check("bp_no_ovf",  64'(overflow),   64'd0);
    step(1'b1, 2'b10, 1'b0, 1'b0);
    check("bp_overflow",  64'(overflow),   64'd1);
    check("bp_count_hold", 64'(dct_count), 64'd15);
    check("bp_buf_hold",  64'(dct_buffer), 64'h1555_5555);
    sb.push_back({2'b10, 4'hF, 30'h1555_5555});
    step(1'b0, 2'b00, 1'b0, 1'b1);
    check("bp_reseal_valid", 64'(tw_valid),  64'd1);
    check("bp_reseal_count", 64'(dct_count), 64'd0);
    check("bp_reseal_tw",    64'(tw),        64'({2'b10, 4'hF, 30'h1555_5555}));
    step(1'b0, 2'b00, 1'b0, 1'b1);
    check("bp_drained", 64'(tw_valid), 64'd0);

    // Coincident drain and seal on the 15th code.
    for (int i = 0; i < 15; i++) step(1'b1, 2'b10, 1'b0, 1'b1);
    sb.push_back({2'b10, 4'hF, 30'h2AAA_AAAA});
    for (int i = 0; i < 14; i++) step(1'b1, 2'b11, 1'b0, 1'b0);
    sb.push_back({2'b10, 4'hF, 30'h3FFF_FFFF});
    step(1'b1, 2'b11, 1'b0, 1'b1);
    check("co_valid", 64'(tw_valid),  64'd1);
    check("co_count", 64'(dct_count), 64'd0);
    check("co_tw",    64'(tw),        64'({2'b10, 4'hF, 30'h3FFF_FFFF}));
    step(1'b0, 2'b00, 1'b0, 1'b1);
    check("co_drained", 64'(tw_valid), 64'd0);

    // Reset mid-fill with an unaccepted word in the slot.
    for (int i = 0; i < 22; i++) step(1'b1, 2'b01, 1'b0, 1'b0);
    check("rm_count7", 64'(dct_count), 64'd7);
    check("rm_valid1", 64'(tw_valid),  64'd1);
    reset = 1'b1;
    #2;
    check("rm_buffer",   64'(dct_buffer), 64'd0);
    check("rm_count",    64'(dct_count),  64'd0);
    check("rm_tw",       64'(tw),         64'd0);
    check("rm_tw_valid", 64'(tw_valid),   64'd0);
    check("rm_overflow", 64'(overflow),   64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // A flush at count 0 with no code is discarded.
    step(1'b0, 2'b00, 1'b1, 1'b1);
    check("f0_no_valid", 64'(tw_valid), 64'd0);
    step(1'b1, 2'b01, 1'b0, 1'b1);
    check("f0_no_pending", 64'(tw_valid), 64'd0);
    check("f0_count1",     64'(dct_count), 64'd1);

    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
